dma_channel: RTL and testbench
==============================

DMA_CHANNEL -- requirements
Module: dma_channel

Interface
REQ-001 SHALL have parameter START, default MAP_DMA0, meaning the base address of the register block (CTL +0, SA +2, DA +4, SZ +6).
REQ-002 SHALL have ports: MCLK in 1, the single clock; reset in 1, asynchronous active-high reset.
REQ-003 SHALL have responder ports: MAB in 16, CPU address; MDBwrite in 16, CPU write data; MW in 1, write strobe; BW in 1, byte access; MDBread out 16, register read data.
REQ-004 SHALL have initiator ports: DMA_REQ out 1, bus request; DMA_GNT in 1, bus grant; DMA_MAB out 16; DMA_MDBwrite out 16; DMA_MW out 1; DMA_BW out 1; DMA_MDBin in 16, bus read data.
REQ-005 SHALL have ports: DMATRIG in 1, hardware trigger (e.g. TimerA CCIFG); DMACLR in 1, interrupt acknowledge; DMAINT out 1, interrupt request.

Function
REQ-006 CTL bits SHALL be: 0 DMAREQ (software trigger, self-clearing, reads 0), 2 DMAIE, 3 DMAIFG, 4 DMAEN, 5 DMADT (0 single, 1 block), 6 DMASRCINCR, 7 DMADSTINCR, 8 DMABYTE; all other bits read 0.
REQ-007 Register writes SHALL take effect on the MCLK edge with MW=1 and MAB matching; BW=1 writes only the addressed byte (MAB[0] selects high byte).
REQ-008 MDBread SHALL be combinational: the selected register when MW=0 and MAB is in range, else 16'h0000 (OR-bus).
REQ-009 A trigger SHALL be a DMATRIG rising edge (sampled on MCLK) or a DMAREQ write of 1, and counts only when DMAEN=1 and SZ!=0.
REQ-010 The FSM SHALL have states IDLE, REQ, READ, WRITE: IDLE->REQ on trigger; REQ->READ when DMA_GNT=1; READ->WRITE; WRITE->READ (block mode, SZ after decrement !=0) else ->IDLE.
REQ-011 DMA_REQ SHALL be 1 in REQ, READ and WRITE, and 0 in IDLE.
REQ-012 In READ, DMA_MAB SHALL equal the working source address with DMA_MW=0; DMA_MDBin SHALL be latched at the end of READ.
REQ-013 In WRITE, DMA_MAB SHALL equal the working destination address with the latched data on DMA_MDBwrite and DMA_MW=1; DMA_BW SHALL equal DMABYTE in READ and WRITE.
REQ-014 Latency SHALL be: trigger at edge k, REQ at k+1; with DMA_GNT already 1, READ at k+2, WRITE at k+3.
REQ-015 At the end of WRITE: SZ decrements by 1; each address with its INCR bit set advances by 1 (byte) or 2 (word), modulo 2^16 (16'hFFFE+2 = 16'h0000).
REQ-016 When SZ reaches 0: DMAEN clears, DMAIFG sets and the FSM returns to IDLE.
REQ-017 DMAINT SHALL equal DMAIFG & DMAIE; DMACLR=1 or a CPU write of 0 clears DMAIFG; a simultaneous set wins.
REQ-018 If DMA_GNT=0 in READ or WRITE, the FSM SHALL hold state with DMA_MW forced 0 and resume when the grant returns.
REQ-019 A trigger during REQ/READ/WRITE SHALL be latched in a one-deep pending flag (extras dropped) and serviced on return to IDLE.
REQ-020 CPU writes of DMAEN=0 mid-transfer SHALL abort after the current WRITE completes, with no IFG and pending cleared; SA/DA/SZ writes while busy are ignored.
REQ-021 SA/DA/SZ SHALL read back working (updated) values.

Reset
REQ-022 On reset all registers, pending, latched data and the FSM (IDLE) SHALL be 0, giving MDBread=0, DMA_REQ=0, DMA_MW=0, DMA_BW=0, DMA_MAB=0, DMA_MDBwrite=0, DMAINT=0.
REQ-023 Reset asserted mid-transfer SHALL drop DMA_MW and DMA_REQ immediately (asynchronously).

Structure
REQ-024 MAP_DMA0, the register offsets, the CTL bit positions and the state encodings SHALL live in the shared PARAMS include.
REQ-025 Register decode/storage SHALL be one sub-module, dma_regs; the FSM and datapath stay in dma_channel.

Verification
REQ-026 SA=0x0200, DA=0x0300, SZ=1, word, both INCR, DMAEN, GNT=1, memory[0x0200]=0xBEEF, pulse DMATRIG -> 0x0300=0xBEEF; IFG set; SZ=0; DMAEN=0; SA=0x0202.
REQ-027 Block mode SZ=4, DMAIE=1, byte, SRC fixed -> four DMA_MW writes to 0x0300..0x0303 on alternate cycles; DMAINT=1 after the last; DMACLR pulse -> DMAINT=0.
REQ-028 Single mode SZ=3, TimerA CCR0 trigger -> exactly one transfer per trigger; a second trigger during a transfer is serviced once afterwards, a third is dropped.
REQ-029 DA=0xFFFE, SZ=2, word, DSTINCR -> writes to 0xFFFE then 0x0000.
REQ-030 Drop DMA_GNT for 3 cycles in WRITE -> DMA_MW=0 during the gap; the write completes once after the grant returns; clear DMAEN mid-block -> stops after the current WRITE, IFG=0.

Source files
------------

// File: rtl/dma_channel_pkg.sv
// Shared definitions for the DMA channel: base address, register offsets,
// CTL bit positions, FSM state encoding and the CPU byte-lane merge helper.
package dma_channel_pkg;

    localparam logic [15:0] MAP_DMA0 = 16'h01C0;

    localparam logic [2:0] OFS_CTL = 3'd0;
    localparam logic [2:0] OFS_SA  = 3'd2;
    localparam logic [2:0] OFS_DA  = 3'd4;
    localparam logic [2:0] OFS_SZ  = 3'd6;

    localparam int unsigned CTL_DMAREQ     = 0;
    localparam int unsigned CTL_DMAIE      = 2;
    localparam int unsigned CTL_DMAIFG     = 3;
    localparam int unsigned CTL_DMAEN      = 4;
    localparam int unsigned CTL_DMADT      = 5;
    localparam int unsigned CTL_DMASRCINCR = 6;
    localparam int unsigned CTL_DMADSTINCR = 7;
    localparam int unsigned CTL_DMABYTE    = 8;

    // Bits 2..8 are stored; DMAREQ is a write-only strobe.
    localparam logic [15:0] CTL_RW_MASK = 16'h01FC;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } dma_state_e;

    // A byte write replaces only the lane selected by the address LSB.
    function automatic logic [15:0] merge_write(
        input logic [15:0] old_val,
        input logic [15:0] wdata,
        input logic        bw,
        input logic        hi
    );
        logic [15:0] res;
        if (!bw)
            res = wdata;
        else if (hi)
            res = {wdata[15:8], old_val[7:0]};
        else
            res = {old_val[15:8], wdata[7:0]};
        return res;
    endfunction

endpackage

// File: rtl/dma_channel_regs.sv
// CPU-visible register block of the DMA channel: decode, read mux and storage
// of CTL/SA/DA/SZ, with hardware updates from the transfer engine.
module dma_regs
    import dma_channel_pkg::*;
#(
    parameter logic [15:0] START = MAP_DMA0
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic [15:0] MAB,
    input  logic [15:0] MDBwrite,
    input  logic        MW,
    input  logic        BW,
    output logic [15:0] MDBread,
    input  logic        busy,
    input  logic        xfer_done,
    input  logic [15:0] sa_nxt,
    input  logic [15:0] da_nxt,
    input  logic [15:0] sz_nxt,
    input  logic        set_ifg,
    input  logic        clr_en,
    input  logic        dmaclr,
    output logic [15:0] sa,
    output logic [15:0] da,
    output logic [15:0] sz,
    output logic        ie,
    output logic        ifg,
    output logic        en,
    output logic        dt,
    output logic        src_incr,
    output logic        dst_incr,
    output logic        byte_mode,
    output logic        sw_req
);

    logic [15:0] ctl_q, ctl_d;
    logic [15:0] sa_q, sa_d;
    logic [15:0] da_q, da_d;
    logic [15:0] sz_q, sz_d;

    logic [15:0] offset;
    logic        in_range;
    logic [2:0]  reg_ofs;
    logic [15:0] cur_val;
    logic [15:0] wval;
    logic        wr_en;

    assign offset   = MAB - START;
    assign in_range = (offset < 16'd8);
    assign reg_ofs  = {offset[2:1], 1'b0};
    assign wr_en    = MW & in_range;

    always_comb begin
        cur_val = '0;
        case (reg_ofs)
            OFS_CTL: cur_val = ctl_q;
            OFS_SA:  cur_val = sa_q;
            OFS_DA:  cur_val = da_q;
            OFS_SZ:  cur_val = sz_q;
            default: cur_val = '0;
        endcase
    end

    assign wval    = merge_write(cur_val, MDBwrite, BW, MAB[0]);
    assign MDBread = (!MW && in_range) ? cur_val : '0;

    always_comb begin
        ctl_d  = ctl_q;
        sa_d   = sa_q;
        da_d   = da_q;
        sz_d   = sz_q;
        sw_req = 1'b0;

        if (wr_en) begin
            case (reg_ofs)
                OFS_CTL: begin
                    ctl_d  = wval & CTL_RW_MASK;
                    sw_req = wval[CTL_DMAREQ];
                end
                OFS_SA:  if (!busy) sa_d = wval;
                OFS_DA:  if (!busy) da_d = wval;
                OFS_SZ:  if (!busy) sz_d = wval;
                default: ;
            endcase
        end

        if (xfer_done) begin
            sa_d = sa_nxt;
            da_d = da_nxt;
            sz_d = sz_nxt;
        end

        // Completion has priority over any clear of the flag in the same cycle.
        if (dmaclr)  ctl_d[CTL_DMAIFG] = 1'b0;
        if (set_ifg) ctl_d[CTL_DMAIFG] = 1'b1;
        if (clr_en)  ctl_d[CTL_DMAEN]  = 1'b0;
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            ctl_q <= '0;
            sa_q  <= '0;
            da_q  <= '0;
            sz_q  <= '0;
        end else begin
            ctl_q <= ctl_d;
            sa_q  <= sa_d;
            da_q  <= da_d;
            sz_q  <= sz_d;
        end
    end

    assign sa        = sa_q;
    assign da        = da_q;
    assign sz        = sz_q;
    assign ie        = ctl_q[CTL_DMAIE];
    assign ifg       = ctl_q[CTL_DMAIFG];
    assign en        = ctl_q[CTL_DMAEN];
    assign dt        = ctl_q[CTL_DMADT];
    assign src_incr  = ctl_q[CTL_DMASRCINCR];
    assign dst_incr  = ctl_q[CTL_DMADSTINCR];
    assign byte_mode = ctl_q[CTL_DMABYTE];

endmodule

// File: rtl/dma_channel.sv
// Single DMA channel: trigger capture, IDLE/REQ/READ/WRITE transfer FSM and
// address/size datapath; register storage lives in dma_regs.
module dma_channel
    import dma_channel_pkg::*;
#(
    parameter logic [15:0] START = MAP_DMA0
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic [15:0] MAB,
    input  logic [15:0] MDBwrite,
    input  logic        MW,
    input  logic        BW,
    output logic [15:0] MDBread,
    output logic        DMA_REQ,
    input  logic        DMA_GNT,
    output logic [15:0] DMA_MAB,
    output logic [15:0] DMA_MDBwrite,
    output logic        DMA_MW,
    output logic        DMA_BW,
    input  logic [15:0] DMA_MDBin,
    input  logic        DMATRIG,
    input  logic        DMACLR,
    output logic        DMAINT
);

    dma_state_e  state_q, state_d;
    logic        pending_q, pending_d;
    logic        trig_prev_q, trig_prev_d;
    logic [15:0] data_q, data_d;

    logic [15:0] sa, da, sz;
    logic [15:0] sa_nxt, da_nxt, sz_nxt;
    logic        ie, ifg, en, dt, src_incr, dst_incr, byte_mode, sw_req;
    logic        xfer_done, set_ifg, clr_en;
    logic        hw_edge, trig_evt, busy;
    logic [15:0] step;

    dma_regs #(
        .START (START)
    ) u_regs (
        .MCLK      (MCLK),
        .reset     (reset),
        .MAB       (MAB),
        .MDBwrite  (MDBwrite),
        .MW        (MW),
        .BW        (BW),
        .MDBread   (MDBread),
        .busy      (busy),
        .xfer_done (xfer_done),
        .sa_nxt    (sa_nxt),
        .da_nxt    (da_nxt),
        .sz_nxt    (sz_nxt),
        .set_ifg   (set_ifg),
        .clr_en    (clr_en),
        .dmaclr    (DMACLR),
        .sa        (sa),
        .da        (da),
        .sz        (sz),
        .ie        (ie),
        .ifg       (ifg),
        .en        (en),
        .dt        (dt),
        .src_incr  (src_incr),
        .dst_incr  (dst_incr),
        .byte_mode (byte_mode),
        .sw_req    (sw_req)
    );

    assign busy        = (state_q != S_IDLE);
    assign trig_prev_d = DMATRIG;
    assign hw_edge     = DMATRIG & ~trig_prev_q;
    assign trig_evt    = (hw_edge | sw_req) & en & (sz != 16'd0);
    assign step        = byte_mode ? 16'd1 : 16'd2;
    assign DMAINT      = ifg & ie;

    // Every trigger lands in the pending flag first, which gives the one-cycle
    // trigger-to-REQ latency and the one-deep queue with the same flop.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | trig_evt;
        data_d       = data_q;
        xfer_done    = 1'b0;
        set_ifg      = 1'b0;
        clr_en       = 1'b0;
        sa_nxt       = src_incr ? sa + step : sa;
        da_nxt       = dst_incr ? da + step : da;
        sz_nxt       = sz - 16'd1;
        DMA_REQ      = 1'b0;
        DMA_MAB      = '0;
        DMA_MDBwrite = '0;
        DMA_MW       = 1'b0;
        DMA_BW       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    pending_d = trig_evt;
                    if (en && (sz != 16'd0))
                        state_d = S_REQ;
                end
            end
            S_REQ: begin
                DMA_REQ = 1'b1;
                if (DMA_GNT)
                    state_d = S_READ;
            end
            S_READ: begin
                DMA_REQ = 1'b1;
                DMA_MAB = sa;
                DMA_BW  = byte_mode;
                if (DMA_GNT) begin
                    data_d  = DMA_MDBin;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                DMA_REQ      = 1'b1;
                DMA_MAB      = da;
                DMA_MDBwrite = data_q;
                DMA_BW       = byte_mode;
                DMA_MW       = DMA_GNT;
                if (DMA_GNT) begin
                    xfer_done = 1'b1;
                    if (!en) begin
                        state_d   = S_IDLE;
                        pending_d = 1'b0;
                    end else if (sz_nxt == 16'd0) begin
                        set_ifg   = 1'b1;
                        clr_en    = 1'b1;
                        state_d   = S_IDLE;
                        pending_d = 1'b0;
                    end else if (dt) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            trig_prev_q <= trig_prev_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: tb/tb_dma_channel.sv
// Self-checking bench for dma_channel: scoreboard of expected bus writes plus
// directed register, latency, grant-gap, abort and reset checks.
module tb_dma_channel;

    localparam logic [15:0] BASE = 16'h0240;
    localparam logic [15:0] A_CTL = BASE + 16'd0;
    localparam logic [15:0] A_SA  = BASE + 16'd2;
    localparam logic [15:0] A_DA  = BASE + 16'd4;
    localparam logic [15:0] A_SZ  = BASE + 16'd6;

    logic        MCLK = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] MAB = '0;
    logic [15:0] MDBwrite = '0;
    logic        MW = 1'b0;
    logic        BW = 1'b0;
    logic [15:0] MDBread;
    logic        DMA_REQ;
    logic        DMA_GNT = 1'b1;
    logic [15:0] DMA_MAB;
    logic [15:0] DMA_MDBwrite;
    logic        DMA_MW;
    logic        DMA_BW;
    logic [15:0] DMA_MDBin;
    logic        DMATRIG = 1'b0;
    logic        DMACLR = 1'b0;
    logic        DMAINT;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        bw;
    } wr_t;

    wr_t         sb_q[$];
    logic [15:0] mem [0:65535];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    int          wr_base;
    logic [15:0] rd;
    logic        seen;

    dma_channel #(
        .START (BASE)
    ) dut (
        .MCLK         (MCLK),
        .reset        (reset),
        .MAB          (MAB),
        .MDBwrite     (MDBwrite),
        .MW           (MW),
        .BW           (BW),
        .MDBread      (MDBread),
        .DMA_REQ      (DMA_REQ),
        .DMA_GNT      (DMA_GNT),
        .DMA_MAB      (DMA_MAB),
        .DMA_MDBwrite (DMA_MDBwrite),
        .DMA_MW       (DMA_MW),
        .DMA_BW       (DMA_BW),
        .DMA_MDBin    (DMA_MDBin),
        .DMATRIG      (DMATRIG),
        .DMACLR       (DMACLR),
        .DMAINT       (DMAINT)
    );

    always #5 MCLK = ~MCLK;

    assign DMA_MDBin = mem[DMA_MAB];

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic exp_write(input logic [15:0] a, input logic [15:0] d, input logic bw);
        sb_q.push_back(wr_t'{addr: a, data: d, bw: bw});
    endtask

    // Bus-side monitor: each sampled DMA_MW is one completed write.
    always @(negedge MCLK) begin
        if (!reset && DMA_MW) begin
            wr_t e;
            n_writes++;
            if (sb_q.size() == 0) begin
                check("unexpected_write_addr", DMA_MAB, 16'hxxxx);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", DMA_MAB, e.addr);
                check("wr_data", DMA_MDBwrite, e.data);
                check("wr_bw", 16'(DMA_BW), 16'(e.bw));
            end
            mem[DMA_MAB] = DMA_MDBwrite;
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input logic bw);
        MAB = a; MDBwrite = d; BW = bw; MW = 1'b1;
        @(posedge MCLK); #1;
        MW = 1'b0; BW = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        @(posedge MCLK); #1;
        MAB = a; MW = 1'b0;
        #1 d = MDBread;
    endtask

    task automatic reg_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] v;
        cpu_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge MCLK); #1;
        end
    endtask

    initial begin
        mem[16'h0000] = 16'h0000;
        mem[16'h0200] = 16'hBEEF;
        mem[16'h0400] = 16'h1234;
        mem[16'h0500] = 16'h1111;
        mem[16'h0502] = 16'h2222;
        mem[16'h0504] = 16'h3333;
        mem[16'h0700] = 16'hAAAA;
        mem[16'h0702] = 16'h5555;
        mem[16'h0800] = 16'hC0DE;
        mem[16'h0802] = 16'hD00D;
        mem[16'h0A00] = 16'h7777;

        // Reset state
        MAB = A_SA;
        #2;
        check("rst_req", 16'(DMA_REQ), 16'd0);
        check("rst_mw", 16'(DMA_MW), 16'd0);
        check("rst_bw", 16'(DMA_BW), 16'd0);
        check("rst_mab", DMA_MAB, 16'h0000);
        check("rst_mdbw", DMA_MDBwrite, 16'h0000);
        check("rst_int", 16'(DMAINT), 16'd0);
        check("rst_mdbread", MDBread, 16'h0000);
        ticks(2);
        reset = 1'b0;
        ticks(1);
        reg_check("rst_ctl", A_CTL, 16'h0000);
        reg_check("rst_sz", A_SZ, 16'h0000);
        reg_check("out_of_range", BASE + 16'd8, 16'h0000);

        // Single word transfer with latency checks
        cpu_write(A_SA, 16'h0200, 1'b0);
        cpu_write(A_DA, 16'h0300, 1'b0);
        cpu_write(A_SZ, 16'h0001, 1'b0);
        cpu_write(A_CTL, 16'h00D0, 1'b0);
        exp_write(16'h0300, 16'hBEEF, 1'b0);
        DMATRIG = 1'b1;
        @(posedge MCLK); #1;
        check("lat_k_req", 16'(DMA_REQ), 16'd0);
        DMATRIG = 1'b0;
        @(posedge MCLK); #1;
        check("lat_k1_req", 16'(DMA_REQ), 16'd1);
        check("lat_k1_mw", 16'(DMA_MW), 16'd0);
        @(posedge MCLK); #1;
        check("lat_k2_mab", DMA_MAB, 16'h0200);
        check("lat_k2_mw", 16'(DMA_MW), 16'd0);
        @(posedge MCLK); #1;
        check("lat_k3_mab", DMA_MAB, 16'h0300);
        check("lat_k3_mw", 16'(DMA_MW), 16'd1);
        check("lat_k3_data", DMA_MDBwrite, 16'hBEEF);
        @(posedge MCLK); #1;
        check("lat_k4_req", 16'(DMA_REQ), 16'd0);
        check("t1_mem", mem[16'h0300], 16'hBEEF);
        reg_check("t1_ctl", A_CTL, 16'h00C8);
        reg_check("t1_sz", A_SZ, 16'h0000);
        reg_check("t1_sa", A_SA, 16'h0202);
        reg_check("t1_da", A_DA, 16'h0302);
        cpu_write(A_SA + 16'd1, 16'hAB00, 1'b1);
        reg_check("byte_write_hi", A_SA, 16'hAB02);
        cpu_write(A_CTL, 16'h00C0, 1'b0);
        reg_check("ifg_cpu_clear", A_CTL, 16'h00C0);

        // Block byte transfer, fixed source, interrupt
        cpu_write(A_SA, 16'h0400, 1'b0);
        cpu_write(A_DA, 16'h0300, 1'b0);
        cpu_write(A_SZ, 16'h0004, 1'b0);
        cpu_write(A_CTL, 16'h01B4, 1'b0);
        for (int i = 0; i < 4; i++) exp_write(16'h0300 + 16'(i), 16'h1234, 1'b1);
        cpu_write(A_CTL, 16'h01B5, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge MCLK); #1;
            seen = DMA_MW;
        end
        check("blk_first_write_seen", 16'(seen), 16'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge MCLK); #1;
            check("blk_gap_mw", 16'(DMA_MW), 16'd0);
            @(posedge MCLK); #1;
            check("blk_alt_mw", 16'(DMA_MW), 16'd1);
        end
        @(posedge MCLK); #1;
        check("blk_int", 16'(DMAINT), 16'd1);
        DMACLR = 1'b1;
        @(posedge MCLK); #1;
        DMACLR = 1'b0;
        check("blk_int_clr", 16'(DMAINT), 16'd0);
        reg_check("blk_sa_fixed", A_SA, 16'h0400);
        reg_check("blk_da", A_DA, 16'h0304);
        reg_check("blk_ctl", A_CTL, 16'h01A4);

        // Single mode, hardware triggers: one pending, one dropped
        cpu_write(A_SA, 16'h0500, 1'b0);
        cpu_write(A_DA, 16'h0600, 1'b0);
        cpu_write(A_SZ, 16'h0003, 1'b0);
        cpu_write(A_CTL, 16'h00D0, 1'b0);
        exp_write(16'h0600, 16'h1111, 1'b0);
        exp_write(16'h0602, 16'h2222, 1'b0);
        wr_base = n_writes;
        DMATRIG = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge MCLK); #1;
            DMATRIG = ~DMATRIG;
        end
        DMATRIG = 1'b0;
        check("sgl_first_done", 16'(n_writes - wr_base), 16'd1);
        ticks(12);
        check("sgl_total", 16'(n_writes - wr_base), 16'd2);
        reg_check("sgl_sz", A_SZ, 16'h0001);
        reg_check("sgl_sa", A_SA, 16'h0504);
        reg_check("sgl_ctl", A_CTL, 16'h00D0);

        // Destination address wrap
        cpu_write(A_SA, 16'h0700, 1'b0);
        cpu_write(A_DA, 16'hFFFE, 1'b0);
        cpu_write(A_SZ, 16'h0002, 1'b0);
        cpu_write(A_CTL, 16'h00F0, 1'b0);
        exp_write(16'hFFFE, 16'hAAAA, 1'b0);
        exp_write(16'h0000, 16'h5555, 1'b0);
        cpu_write(A_CTL, 16'h00F1, 1'b0);
        ticks(10);
        reg_check("wrap_da", A_DA, 16'h0002);
        reg_check("wrap_ctl", A_CTL, 16'h00E8);

        // Grant gap in WRITE, then abort by clearing DMAEN mid-block
        cpu_write(A_SA, 16'h0800, 1'b0);
        cpu_write(A_DA, 16'h0900, 1'b0);
        cpu_write(A_SZ, 16'h0003, 1'b0);
        cpu_write(A_CTL, 16'h00F0, 1'b0);
        exp_write(16'h0900, 16'hC0DE, 1'b0);
        exp_write(16'h0902, 16'hD00D, 1'b0);
        wr_base = n_writes;
        cpu_write(A_CTL, 16'h00F1, 1'b0);
        ticks(3);
        DMA_GNT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("gap_mw", 16'(DMA_MW), 16'd0);
            check("gap_req", 16'(DMA_REQ), 16'd1);
            check("gap_mab", DMA_MAB, 16'h0900);
            @(posedge MCLK); #1;
        end
        DMA_GNT = 1'b1;
        @(posedge MCLK); #1;
        check("gap_one_write", 16'(n_writes - wr_base), 16'd1);
        cpu_write(A_CTL, 16'h00E0, 1'b0);
        ticks(8);
        check("abort_writes", 16'(n_writes - wr_base), 16'd2);
        check("abort_req", 16'(DMA_REQ), 16'd0);
        reg_check("abort_sz", A_SZ, 16'h0001);
        reg_check("abort_ctl", A_CTL, 16'h00E0);

        // Asynchronous reset during a granted WRITE
        cpu_write(A_SA, 16'h0A00, 1'b0);
        cpu_write(A_DA, 16'h0B00, 1'b0);
        cpu_write(A_SZ, 16'h0001, 1'b0);
        cpu_write(A_CTL, 16'h00D0, 1'b0);
        cpu_write(A_CTL, 16'h00D1, 1'b0);
        ticks(3);
        check("arst_pre_mw", 16'(DMA_MW), 16'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_mw", 16'(DMA_MW), 16'd0);
        check("arst_req", 16'(DMA_REQ), 16'd0);
        check("arst_mab", DMA_MAB, 16'h0000);
        @(posedge MCLK); #1;
        reset = 1'b0;
        reg_check("arst_sz", A_SZ, 16'h0000);
        reg_check("arst_ctl", A_CTL, 16'h0000);

        check("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
